// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared state encoding, default parameters and sizing helpers
package decrypt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEF_DATA_W = 61;
  localparam int DEF_KEY_W = 11;
  localparam int DEF_TAG_W = 6;
  localparam int DEF_SLICE_W = 16;
  localparam logic [5:0] DEF_INV_PAT = 6'b010110;
  function automatic int nslice(input int dw, input int sw);
    return (dw + sw - 1) / sw;
  endfunction
  function automatic int ncopy(input int dw, input int kw);
    return (dw + kw - 2) / kw;
  endfunction
endpackage

// File: rtl/decrypt_function_serial_key_mask_gen.sv
// key_mask_gen: tiles the key (optionally inverted per copy) into a DATA_W-1 bit mask, zero-extended
module key_mask_gen
  import decrypt_pkg::*;
#(
  parameter int KEY_W = DEF_KEY_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ncopy(DATA_W, KEY_W)-1:0] INV_PAT = DEF_INV_PAT
) (
  input  logic [KEY_W-1:0]  key_i,
  output logic [DATA_W-1:0] mask_o
);
  localparam int NC = ncopy(DATA_W, KEY_W);
  logic [NC*KEY_W-1:0] rep;
  for (genvar i = 0; i < NC; i++) begin : g_copy
    assign rep[i*KEY_W +: KEY_W] = key_i ^ {KEY_W{INV_PAT[i]}};
  end
  // the top copy is truncated by keeping only the low DATA_W-1 bits
  assign mask_o = {1'b0, (DATA_W-1)'(rep)};
endmodule

// File: rtl/decrypt_function_serial.sv
// decrypt_function_serial: slice-serial payload +/- key mask with valid/ready handshakes
module decrypt_function_serial
  import decrypt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEY_W = DEF_KEY_W,
  parameter int TAG_W = DEF_TAG_W,
  parameter int SLICE_W = DEF_SLICE_W,
  parameter logic [ncopy(DATA_W, KEY_W)-1:0] INV_PAT = DEF_INV_PAT
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic [DATA_W+KEY_W+TAG_W-1:0]   data_in,
  input  logic                            op_add,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               res_out,
  output logic [DATA_W-2:0]               msg_out,
  output logic [TAG_W-1:0]                tag_out
);
  localparam int NS = nslice(DATA_W, SLICE_W);
  localparam int PW = NS * SLICE_W;
  localparam int IW = $clog2(NS + 1);
  state_e state_q;
  logic [PW-1:0] pay_q, mask_q, acc_q, acc_d;
  logic [DATA_W-1:0] mask, res_q;
  logic [TAG_W-1:0] tag_q, tag_out_q;
  logic [IW-1:0] idx_q;
  logic op_q, cy_q, out_valid_q;
  logic [SLICE_W:0] sl;
  key_mask_gen #(.KEY_W(KEY_W), .DATA_W(DATA_W), .INV_PAT(INV_PAT)) u_mask (
    .key_i(data_in[TAG_W +: KEY_W]),
    .mask_o(mask)
  );
  // operands shift right each slice; results enter at the top so slice 0 lands at the LSB
  always_comb begin
    sl = op_q ? {1'b0, pay_q[SLICE_W-1:0]} + {1'b0, mask_q[SLICE_W-1:0]} + {{SLICE_W{1'b0}}, cy_q}
              : {1'b0, pay_q[SLICE_W-1:0]} - {1'b0, mask_q[SLICE_W-1:0]} - {{SLICE_W{1'b0}}, cy_q};
    acc_d = PW'({sl[SLICE_W-1:0], acc_q} >> SLICE_W);
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      pay_q <= '0;
      mask_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      tag_q <= '0;
      tag_out_q <= '0;
      idx_q <= '0;
      op_q <= 1'b0;
      cy_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          pay_q <= PW'(data_in[TAG_W+KEY_W +: DATA_W]);
          mask_q <= PW'(mask);
          tag_q <= data_in[TAG_W-1:0];
          op_q <= op_add;
          idx_q <= '0;
          cy_q <= 1'b0;
          state_q <= RUN;
        end
        RUN: if (idx_q == IW'(NS)) begin
          res_q <= acc_q[DATA_W-1:0];
          tag_out_q <= tag_q;
          out_valid_q <= 1'b1;
          state_q <= DONE;
        end else begin
          acc_q <= acc_d;
          pay_q <= pay_q >> SLICE_W;
          mask_q <= mask_q >> SLICE_W;
          cy_q <= sl[SLICE_W];
          idx_q <= idx_q + 1'b1;
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = out_valid_q;
  assign res_out = res_q;
  assign msg_out = res_q[DATA_W-1:1];
  assign tag_out = tag_out_q;
endmodule

// File: tb/tb_decrypt_function_serial.sv
// tb_decrypt_function_serial: directed checks on the default build plus a narrow-parameter random sweep
module tb_decrypt_function_serial;
  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;
  logic [77:0] d0;
  logic op0, iv0, ir0, ov0, or0;
  logic [60:0] res0;
  logic [59:0] msg0;
  logic [5:0] tag0;
  logic [45:0] d1;
  logic op1, iv1, ir1, ov1, or1;
  logic [32:0] res1;
  logic [31:0] msg1;
  logic [5:0] tag1;
  int total = 0;
  int bad = 0;
  decrypt_function_serial dut0 (
    .Clk(Clk), .Rst(Rst), .data_in(d0), .op_add(op0), .in_valid(iv0), .in_ready(ir0),
    .out_valid(ov0), .out_ready(or0), .res_out(res0), .msg_out(msg0), .tag_out(tag0)
  );
  decrypt_function_serial #(.DATA_W(33), .KEY_W(7), .SLICE_W(8), .INV_PAT(5'b10101)) dut1 (
    .Clk(Clk), .Rst(Rst), .data_in(d1), .op_add(op1), .in_valid(iv1), .in_ready(ir1),
    .out_valid(ov1), .out_ready(or1), .res_out(res1), .msg_out(msg1), .tag_out(tag1)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic start0(input logic [60:0] p, input logic [10:0] k, input logic [5:0] t,
                        input logic op, output int lat);
    @(negedge Clk);
    d0 = {p, k, t};
    op0 = op;
    iv0 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    iv0 = 1'b0;
    d0 = ~d0;
    op0 = ~op;
    lat = 0;
    while (!ov0 && lat < 40) begin
      @(posedge Clk);
      lat++;
      @(negedge Clk);
    end
  endtask
  task automatic finish0;
    or0 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    or0 = 1'b0;
  endtask
  function automatic logic [32:0] mdl(input logic [32:0] p, input logic [6:0] k, input logic op);
    logic [32:0] m;
    logic [4:0] pat;
    pat = 5'b10101;
    m = '0;
    for (int b = 0; b < 32; b++) m[b] = k[b % 7] ^ pat[b / 7];
    return op ? p + m : p - m;
  endfunction
  initial begin
    int lat;
    logic [60:0] r, hold;
    logic [63:0] rr;
    logic [32:0] p1;
    logic seen;
    Rst = 1'b1;
    d0 = '0; op0 = 1'b0; iv0 = 1'b0; or0 = 1'b0;
    d1 = '0; op1 = 1'b0; iv1 = 1'b0; or1 = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    chk("rst_ov", 64'(ov0), 64'd0);
    chk("rst_ir", 64'(ir0), 64'd1);
    chk("rst_res", 64'(res0), 64'd0);
    chk("rst_msg", 64'(msg0), 64'd0);
    chk("rst_tag", 64'(tag0), 64'd0);
    chk("rst_ov1", 64'(ov1), 64'd0);
    chk("rst_ir1", 64'(ir1), 64'd1);
    start0(61'h7FF001FFFFF802, 11'h000, 6'h2A, 1'b0, lat);
    chk("k0_lat", 64'(lat), 64'd5);
    chk("k0_res", 64'(res0), 64'd2);
    chk("k0_msg", 64'(msg0), 64'd1);
    chk("k0_tag", 64'(tag0), 64'h2A);
    chk("k0_ir", 64'(ir0), 64'd0);
    finish0;
    chk("k0_ovdrop", 64'(ov0), 64'd0);
    chk("k0_irback", 64'(ir0), 64'd1);
    start0(61'h0, 11'h7FF, 6'h15, 1'b0, lat);
    chk("borrow_res", 64'(res0), 64'h107FF001FFFFF801);
    chk("borrow_tag", 64'(tag0), 64'h15);
    finish0;
    start0(61'h0, 11'h000, 6'h01, 1'b0, lat);
    chk("sub0_res", 64'(res0), 64'h1F800FFE00000800);
    finish0;
    or0 = 1'b1;
    start0({61{1'b1}}, 11'h000, 6'h3F, 1'b1, lat);
    chk("carry_lat", 64'(lat), 64'd5);
    chk("carry_res", 64'(res0), 64'h7FF001FFFFF7FF);
    finish0;
    chk("early_rdy_ov", 64'(ov0), 64'd0);
    start0({60'h123456789ABCDEF, 1'b0}, 11'h2A5, 6'h0C, 1'b1, lat);
    r = res0;
    finish0;
    start0(r, 11'h2A5, 6'h0C, 1'b0, lat);
    chk("rt_msg", 64'(msg0), 64'h123456789ABCDEF);
    chk("rt_res", 64'(res0), 64'h2468ACF13579BDE);
    finish0;
    start0(61'h7FF001FFFFF802, 11'h000, 6'h2A, 1'b0, lat);
    hold = res0;
    chk("bp_res0", 64'(hold), 64'd2);
    for (int i = 0; i < 10; i++) begin
      iv0 = 1'b1;
      d0 = {61'(i), 11'h155, 6'(i)};
      @(posedge Clk);
      @(negedge Clk);
      chk("bp_res", 64'(res0), 64'd2);
      chk("bp_tag", 64'(tag0), 64'h2A);
      chk("bp_ov", 64'(ov0), 64'd1);
      chk("bp_ir", 64'(ir0), 64'd0);
    end
    iv0 = 1'b0;
    finish0;
    chk("bp_ovdrop", 64'(ov0), 64'd0);
    chk("bp_irback", 64'(ir0), 64'd1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      seen = seen | ov0;
    end
    chk("bp_noqueue", 64'(seen), 64'd0);
    @(negedge Clk);
    d0 = {61'h0, 11'h7FF, 6'h33};
    op0 = 1'b0;
    iv0 = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    iv0 = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    chk("abort_ov", 64'(ov0), 64'd0);
    chk("abort_ir", 64'(ir0), 64'd1);
    chk("abort_res", 64'(res0), 64'd0);
    chk("abort_msg", 64'(msg0), 64'd0);
    chk("abort_tag", 64'(tag0), 64'd0);
    seen = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      seen = seen | ov0;
    end
    chk("abort_noout", 64'(seen), 64'd0);
    for (int n = 0; n < 1000; n++) begin
      rr = {$urandom, $urandom};
      p1 = rr[32:0];
      @(negedge Clk);
      d1 = {p1, rr[39:33], rr[45:40]};
      op1 = rr[46];
      iv1 = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      iv1 = 1'b0;
      d1 = ~d1;
      op1 = ~rr[46];
      lat = 0;
      while (!ov1 && lat < 40) begin
        @(posedge Clk);
        lat++;
        @(negedge Clk);
      end
      chk("sw_lat", 64'(lat), 64'd6);
      chk("sw_res", 64'(res1), 64'(mdl(p1, rr[39:33], rr[46])));
      chk("sw_tag", 64'(tag1), 64'(rr[45:40]));
      or1 = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      or1 = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decrypt_function_serial.md
DECRYPT_FUNCTION_SERIAL -- requirements
Module: decrypt_function_serial

Interface
REQ-001 SHALL have parameter DATA_W, default 61: ciphertext payload width; recovered message is DATA_W-1 bits.
REQ-002 SHALL have parameter KEY_W, default 11: key width.
REQ-003 SHALL have parameter TAG_W, default 6: low packet field, passed through unmodified.
REQ-004 SHALL have parameter SLICE_W, default 16: adder/subtractor slice width; NSLICE = ceil(DATA_W/SLICE_W).
REQ-005 SHALL have parameter INV_PAT, width ceil((DATA_W-1)/KEY_W), default 6'b010110: bit i=1 inverts key copy i in the mask.
REQ-006 SHALL have port Clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port Rst, input, 1: synchronous active-high reset; one clock; reset is synchronous and active-high.
REQ-008 SHALL have port data_in, input, DATA_W+KEY_W+TAG_W: packet {payload, key, tag}, tag in the LSBs.
REQ-009 SHALL have port op_add, input, 1: 0 = payload minus mask (decrypt), 1 = payload plus mask (encrypt).
REQ-010 SHALL have port in_valid, input, 1, and port in_ready, output, 1: input handshake.
REQ-011 SHALL have port out_valid, output, 1, and port out_ready, input, 1: output handshake.
REQ-012 SHALL have port res_out, output, DATA_W: full arithmetic result.
REQ-013 SHALL have port msg_out, output, DATA_W-1: res_out[DATA_W-1:1].
REQ-014 SHALL have port tag_out, output, TAG_W: tag captured with the packet.

Function
REQ-015 Mask M SHALL be DATA_W-1 bits built from key copies; copy i occupies bits [i*KEY_W +: KEY_W], inverted if INV_PAT[i]; the last copy is truncated to its low bits. M SHALL be zero-extended to DATA_W.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 In IDLE: in_ready=1; in_valid=1 SHALL capture payload, M, tag and op_add, clear slice index and carry/borrow, and move to RUN.
REQ-018 RUN SHALL process one SLICE_W slice per cycle, LSB slice first, chaining carry (add) or borrow (sub) between slices.
REQ-019 After slice NSLICE-1, the FSM SHALL go to DONE with out_valid=1; latency is NSLICE+1 cycles from the accept edge to out_valid.
REQ-020 Arithmetic SHALL be modulo 2^DATA_W; the final carry/borrow SHALL be discarded; the last partial slice SHALL be masked to DATA_W.
REQ-021 In DONE, res_out, msg_out and tag_out SHALL be held stable until out_ready=1; then the FSM SHALL return to IDLE, with out_valid=0 on the next cycle.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored, with no queueing.
REQ-023 Inputs data_in and op_add SHALL be sampled only on the accept edge; later changes SHALL have no effect on the current result.
REQ-024 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-025 Rst=1 at a clock edge SHALL force IDLE, out_valid=0, res_out=0, msg_out=0, tag_out=0, slice index=0, carry/borrow=0.
REQ-026 Rst SHALL abort any RUN/DONE transaction without producing output; in_ready=1 on the first cycle after Rst deasserts.
REQ-027 Rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 Package decrypt_pkg SHALL hold the state enum, default parameter values, and the NSLICE/copy-count helper functions.
REQ-029 Mask construction SHALL be one combinational sub-module, key_mask_gen (parameters KEY_W, DATA_W, INV_PAT).

Verification
REQ-030 key=0, op_add=0, payload=M(0)+2 -> res_out=2, msg_out=1, out_valid 5 cycles after accept (defaults).
REQ-031 Borrow chain: payload=0, key=11'h7FF, op_add=0 -> res_out=(2^61 - M(7FF)) mod 2^61; checks borrow across all 4 slices.
REQ-032 Round trip: encrypt msg=60'h123456789ABCDEF with key=11'h2A5 and payload={msg,1'b0} -> feed res_out back with op_add=0 -> msg_out=60'h123456789ABCDEF.
REQ-033 Back-pressure: out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, and in_valid pulses are dropped.
REQ-034 Rst asserted during the RUN cycle for slice 2 -> out_valid never rises; state=IDLE and all outputs 0 the next cycle.
REQ-035 Parameter sweep DATA_W=33, KEY_W=7, SLICE_W=8, INV_PAT=5'b10101 -> results match the reference model over 1000 random packets.
